// File: rtl/rf_port_sequencer.sv
// rf_port_sequencer: shares one regfile port between buffered writeback writes and two-operand reads.
// Define RF_SEQ_BYPASS_EN to forward pending write data to hazarded reads instead of stalling them.
module rf_port_sequencer #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int WB_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            rd_req_valid,
    output logic            rd_req_ready,
    input  logic [AW-1:0]   rd_rs1_addr,
    input  logic [AW-1:0]   rd_rs2_addr,
    output logic            rd_rsp_valid,
    output logic [XLEN-1:0] rd_rs1_data,
    output logic [XLEN-1:0] rd_rs2_data,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            rf_write_ena,
    output logic [AW-1:0]   rf_write_addr,
    output logic [XLEN-1:0] rf_write_data,
    output logic [AW-1:0]   rf_read1_addr,
    output logic [AW-1:0]   rf_read2_addr,
    input  logic [XLEN-1:0] rf_read1_data,
    input  logic [XLEN-1:0] rf_read2_data
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]   fa [WB_DEPTH];
    logic [XLEN-1:0] fd [WB_DEPTH];
    logic [PW-1:0]   wptr, rptr, idx;
    logic [CW-1:0]   count;
    logic [AW-1:0]   held1, held2;
    logic            full, push, pop, m1, m2, haz1, haz2, allowed, rd_cyc;
`ifdef RF_SEQ_BYPASS_EN
    logic [XLEN-1:0] y1, y2, byp1, byp2;
    logic            f1, f2;
`endif

    assign full     = count == CW'(WB_DEPTH);
    assign wb_ready = rstn && !full;
    assign push     = wb_valid && wb_ready && wb_addr != '0;

    // Walk oldest to newest so the last hit is the youngest; the incoming write overrides all.
    always_comb begin
        m1  = 1'b0;
        m2  = 1'b0;
        idx = '0;
`ifdef RF_SEQ_BYPASS_EN
        y1 = '0;
        y2 = '0;
`endif
        for (int i = 0; i < WB_DEPTH; i++) begin
            idx = rptr + PW'(i);
            if (CW'(i) < count && fa[idx] == rd_rs1_addr) begin
                m1 = 1'b1;
`ifdef RF_SEQ_BYPASS_EN
                y1 = fd[idx];
`endif
            end
            if (CW'(i) < count && fa[idx] == rd_rs2_addr) begin
                m2 = 1'b1;
`ifdef RF_SEQ_BYPASS_EN
                y2 = fd[idx];
`endif
            end
        end
        if (push && wb_addr == rd_rs1_addr) begin
            m1 = 1'b1;
`ifdef RF_SEQ_BYPASS_EN
            y1 = wb_data;
`endif
        end
        if (push && wb_addr == rd_rs2_addr) begin
            m2 = 1'b1;
`ifdef RF_SEQ_BYPASS_EN
            y2 = wb_data;
`endif
        end
    end

    assign haz1 = rd_rs1_addr != '0 && m1;
    assign haz2 = rd_rs2_addr != '0 && m2;
`ifdef RF_SEQ_BYPASS_EN
    assign allowed = 1'b1;
`else
    assign allowed = !(haz1 || haz2);
`endif
    assign rd_cyc = rstn && !full && rd_req_valid && allowed;
    assign pop    = rstn && (full || (!rd_cyc && count != '0));

    assign rd_req_ready  = rd_cyc;
    assign rf_write_ena  = pop;
    assign rf_write_addr = fa[rptr];
    assign rf_write_data = fd[rptr];
    assign rf_read1_addr = rd_cyc ? rd_rs1_addr : held1;
    assign rf_read2_addr = rd_cyc ? rd_rs2_addr : held2;

`ifdef RF_SEQ_BYPASS_EN
    assign rd_rs1_data = f1 ? byp1 : rf_read1_data;
    assign rd_rs2_data = f2 ? byp2 : rf_read2_data;
`else
    assign rd_rs1_data = rf_read1_data;
    assign rd_rs2_data = rf_read2_data;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            fa[wptr] <= wb_addr;
            fd[wptr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            rd_rsp_valid <= 1'b0;
            held1        <= '0;
            held2        <= '0;
`ifdef RF_SEQ_BYPASS_EN
            f1   <= 1'b0;
            f2   <= 1'b0;
            byp1 <= '0;
            byp2 <= '0;
`endif
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop) rptr <= rptr + PW'(1);
            count        <= count + CW'(push) - CW'(pop);
            rd_rsp_valid <= rd_cyc;
            if (rd_cyc) begin
                held1 <= rd_rs1_addr;
                held2 <= rd_rs2_addr;
            end
`ifdef RF_SEQ_BYPASS_EN
            f1 <= rd_cyc && haz1;
            f2 <= rd_cyc && haz2;
            if (rd_cyc && haz1) byp1 <= y1;
            if (rd_cyc && haz2) byp2 <= y2;
`endif
        end
    end
endmodule

// File: tb/tb_rf_port_sequencer.sv
// tb_rf_port_sequencer: directed bench for rf_port_sequencer with a behavioural regfile behind the port.
module tb_rf_port_sequencer;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        rd_req_valid = 1'b0, wb_valid = 1'b0;
    logic [4:0]  rd_rs1_addr = '0, rd_rs2_addr = '0, wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        rd_req_ready, rd_rsp_valid, wb_ready, rf_write_ena;
    logic [31:0] rd_rs1_data, rd_rs2_data, rf_write_data, r1, r2;
    logic [4:0]  rf_write_addr, rf_read1_addr, rf_read2_addr;
    logic [31:0] mem [32] = '{default: 32'h0};
    int          wr_cnt = 0;
    int          tests = 0, fails = 0;
`ifdef RF_SEQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    rf_port_sequencer dut (
        .clk(clk), .rstn(rstn),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_rs1_addr(rd_rs1_addr), .rd_rs2_addr(rd_rs2_addr),
        .rd_rsp_valid(rd_rsp_valid), .rd_rs1_data(rd_rs1_data), .rd_rs2_data(rd_rs2_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_write_ena(rf_write_ena), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_read1_addr(rf_read1_addr), .rf_read2_addr(rf_read2_addr),
        .rf_read1_data(r1), .rf_read2_data(r2)
    );

    // Regfile: one-cycle registered read, x0 hardwired to zero.
    always @(posedge clk) begin
        if (rf_write_ena) begin
            if (rf_write_addr != 0) mem[rf_write_addr] <= rf_write_data;
            wr_cnt <= wr_cnt + 1;
        end else begin
            r1 <= (rf_read1_addr == 0) ? 32'h0 : mem[rf_read1_addr];
            r2 <= (rf_read2_addr == 0) ? 32'h0 : mem[rf_read2_addr];
        end
    end

    task automatic step; @(posedge clk); #1; endtask
    task automatic settle; #1; endtask
    task automatic idle;
        rd_req_valid = 0; wb_valid = 0; rd_rs1_addr = 0; rd_rs2_addr = 0; wb_addr = 0; wb_data = 0;
    endtask
    task automatic drain; idle(); repeat (6) step(); endtask
    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 16; i++) begin
            settle();
            if (rd_req_ready) begin ok = 1; break; end
            step();
        end
    endtask

    task automatic test_reset;
        rstn = 0; idle(); wb_valid = 1; wb_addr = 3; rd_req_valid = 1;
        repeat (2) begin
            step(); settle();
            tests++; if (rd_rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b exp 0", rd_rsp_valid); end
            tests++; if (rf_write_ena !== 1'b0) begin fails++; $display("FAIL reset_write_ena got %b exp 0", rf_write_ena); end
            tests++; if (rd_req_ready !== 1'b0) begin fails++; $display("FAIL reset_rd_ready got %b exp 0", rd_req_ready); end
            tests++; if (wb_ready !== 1'b0) begin fails++; $display("FAIL reset_wb_ready got %b exp 0", wb_ready); end
        end
        rstn = 1; idle(); settle();
        tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL post_reset_wb_ready got %b exp 1", wb_ready); end
        tests++; if (rf_write_ena !== 1'b0) begin fails++; $display("FAIL post_reset_write_ena got %b exp 0", rf_write_ena); end
        step(); settle();
        tests++; if (rd_rsp_valid !== 1'b0) begin fails++; $display("FAIL post_reset_rsp got %b exp 0", rd_rsp_valid); end
    endtask

    task automatic test_write_read;
        step(); wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; settle();
        tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL wr_wb_ready got %b exp 1", wb_ready); end
        step(); idle(); settle();
        tests++; if (rf_write_ena !== 1'b1) begin fails++; $display("FAIL wr_commit_ena got %b exp 1", rf_write_ena); end
        tests++; if (rf_write_addr !== 5'd5) begin fails++; $display("FAIL wr_commit_addr got %0d exp 5", rf_write_addr); end
        tests++; if (rf_write_data !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_commit_data got %h exp deadbeef", rf_write_data); end
        step(); settle();
        tests++; if (rf_write_ena !== 1'b0) begin fails++; $display("FAIL wr_single_pulse got %b exp 0", rf_write_ena); end
        step(); rd_req_valid = 1; rd_rs1_addr = 5; rd_rs2_addr = 0; settle();
        tests++; if (rd_req_ready !== 1'b1) begin fails++; $display("FAIL rd_ready got %b exp 1", rd_req_ready); end
        tests++; if (rf_read1_addr !== 5'd5 || rf_write_ena !== 1'b0) begin fails++; $display("FAIL rd_port got addr %0d ena %b exp 5 0", rf_read1_addr, rf_write_ena); end
        step(); idle(); settle();
        tests++; if (rd_rsp_valid !== 1'b1) begin fails++; $display("FAIL rd_rsp_valid got %b exp 1", rd_rsp_valid); end
        tests++; if (rd_rs1_data !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_rs1_data got %h exp deadbeef", rd_rs1_data); end
        tests++; if (rd_rs2_data !== 32'h0) begin fails++; $display("FAIL rd_rs2_x0 got %h exp 0", rd_rs2_data); end
        step(); settle();
        tests++; if (rd_rsp_valid !== 1'b0) begin fails++; $display("FAIL rd_rsp_pulse got %b exp 0", rd_rsp_valid); end
    endtask

    task automatic test_hazard_same;
        bit ok;
        step(); wb_valid = 1; wb_addr = 7; wb_data = 32'h11; rd_req_valid = 1; rd_rs1_addr = 7; rd_rs2_addr = 0; settle();
        tests++; if (rd_req_ready !== BYP) begin fails++; $display("FAIL haz_same_ready got %b exp %b", rd_req_ready, BYP); end
        ok = rd_req_ready;
        if (!ok) begin step(); wb_valid = 0; wait_ready(ok); end
        tests++; if (!ok) begin fails++; $display("FAIL haz_same_accept got timeout exp accept"); end
        step(); idle(); settle();
        tests++; if (rd_rsp_valid !== 1'b1) begin fails++; $display("FAIL haz_same_rsp got %b exp 1", rd_rsp_valid); end
        tests++; if (rd_rs1_data !== 32'h11) begin fails++; $display("FAIL haz_same_data got %h exp 11", rd_rs1_data); end
        drain();
    endtask

    task automatic test_youngest;
        bit ok;
        step(); wb_valid = 1; wb_addr = 3; wb_data = 32'hA; settle();
        step(); wb_data = 32'hB; rd_req_valid = 1; rd_rs1_addr = 3; rd_rs2_addr = 3; settle();
        tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL young_wb_ready got %b exp 1", wb_ready); end
        ok = rd_req_ready;
        if (!ok) begin step(); wb_valid = 0; wait_ready(ok); end
        tests++; if (!ok) begin fails++; $display("FAIL young_accept got timeout exp accept"); end
        step(); idle(); settle();
        tests++; if (rd_rsp_valid !== 1'b1) begin fails++; $display("FAIL young_rsp got %b exp 1", rd_rsp_valid); end
        tests++; if (rd_rs1_data !== 32'hB || rd_rs2_data !== 32'hB) begin fails++; $display("FAIL young_data got %h %h exp b b", rd_rs1_data, rd_rs2_data); end
        drain();
    endtask

    task automatic test_full_back_to_back;
        for (int k = 1; k <= 4; k++) begin
            step(); wb_valid = 1; wb_addr = 5'(k); wb_data = 32'h100 * k; rd_req_valid = 1; rd_rs1_addr = 5; rd_rs2_addr = 0; settle();
            tests++; if (wb_ready !== 1'b1 || rd_req_ready !== 1'b1) begin fails++; $display("FAIL fill_%0d got wb %b rd %b exp 1 1", k, wb_ready, rd_req_ready); end
            if (k > 1) begin
                tests++; if (rd_rsp_valid !== 1'b1 || rd_rs1_data !== 32'hDEADBEEF) begin fails++; $display("FAIL b2b_%0d got v %b d %h exp 1 deadbeef", k, rd_rsp_valid, rd_rs1_data); end
            end
        end
        step(); wb_valid = 0; settle();
        tests++; if (wb_ready !== 1'b0 || rd_req_ready !== 1'b0) begin fails++; $display("FAIL full_ready got wb %b rd %b exp 0 0", wb_ready, rd_req_ready); end
        tests++; if (rf_write_ena !== 1'b1 || rf_write_addr !== 5'd1 || rf_write_data !== 32'h100) begin fails++; $display("FAIL full_pop got %b %0d %h exp 1 1 100", rf_write_ena, rf_write_addr, rf_write_data); end
        step(); settle();
        tests++; if (rd_req_ready !== 1'b1 || rd_rsp_valid !== 1'b0 || wb_ready !== 1'b1) begin fails++; $display("FAIL full_resume got rd %b rsp %b wb %b exp 1 0 1", rd_req_ready, rd_rsp_valid, wb_ready); end
        step(); idle(); settle();
        tests++; if (rd_rsp_valid !== 1'b1) begin fails++; $display("FAIL full_resume_rsp got %b exp 1", rd_rsp_valid); end
        drain();
    endtask

    task automatic test_x0;
        int n;
        n = wr_cnt;
        step(); wb_valid = 1; wb_addr = 0; wb_data = 32'hFFFF; settle();
        tests++; if (wb_ready !== 1'b1) begin fails++; $display("FAIL x0_wb_ready got %b exp 1", wb_ready); end
        step(); idle(); settle();
        tests++; if (rf_write_ena !== 1'b0) begin fails++; $display("FAIL x0_no_write got %b exp 0", rf_write_ena); end
        step(); rd_req_valid = 1; settle();
        tests++; if (rd_req_ready !== 1'b1) begin fails++; $display("FAIL x0_rd_ready got %b exp 1", rd_req_ready); end
        step(); idle(); settle();
        tests++; if (rd_rsp_valid !== 1'b1 || rd_rs1_data !== 0 || rd_rs2_data !== 0) begin fails++; $display("FAIL x0_read got %b %h %h exp 1 0 0", rd_rsp_valid, rd_rs1_data, rd_rs2_data); end
        tests++; if (wr_cnt !== n) begin fails++; $display("FAIL x0_write_count got %0d exp %0d", wr_cnt, n); end
        drain();
    endtask

    task automatic test_reset_midop;
        int n;
        n = wr_cnt;
        for (int k = 0; k < 3; k++) begin
            step(); wb_valid = 1; wb_addr = 5'(20 + k); wb_data = 32'(k + 1); rd_req_valid = 1; rd_rs1_addr = 9; rd_rs2_addr = 9; settle();
            tests++; if (rd_req_ready !== 1'b1) begin fails++; $display("FAIL midop_rd_%0d got %b exp 1", k, rd_req_ready); end
        end
        step(); idle(); rstn = 0; settle();
        tests++; if (rf_write_ena !== 1'b0 || wb_ready !== 1'b0) begin fails++; $display("FAIL midop_in_reset got ena %b wb %b exp 0 0", rf_write_ena, wb_ready); end
        step(); rstn = 1; settle();
        tests++; if (rd_rsp_valid !== 1'b0 || rf_write_ena !== 1'b0) begin fails++; $display("FAIL midop_after got rsp %b ena %b exp 0 0", rd_rsp_valid, rf_write_ena); end
        repeat (5) step();
        tests++; if (wr_cnt !== n) begin fails++; $display("FAIL midop_writes got %0d exp %0d", wr_cnt, n); end
        rd_req_valid = 1; rd_rs1_addr = 20; rd_rs2_addr = 21; settle();
        tests++; if (rd_req_ready !== 1'b1) begin fails++; $display("FAIL midop_read_ready got %b exp 1", rd_req_ready); end
        step(); rd_rs1_addr = 22; rd_rs2_addr = 0; settle();
        tests++; if (rd_rsp_valid !== 1'b1 || rd_rs1_data !== 0 || rd_rs2_data !== 0) begin fails++; $display("FAIL midop_read_a got %b %h %h exp 1 0 0", rd_rsp_valid, rd_rs1_data, rd_rs2_data); end
        step(); idle(); settle();
        tests++; if (rd_rsp_valid !== 1'b1 || rd_rs1_data !== 0) begin fails++; $display("FAIL midop_read_b got %b %h exp 1 0", rd_rsp_valid, rd_rs1_data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        drain();
        test_hazard_same();
        test_youngest();
        test_full_back_to_back();
        test_x0();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
